control_decode_stage: RTL and testbench
=======================================

// Module: control_decode_stage
// PURPOSE
// - Registered, parametrised ID stage: decodes RV32I instruction into control bundle, holds it in ID/EX register.
// - Adds over combinational decoder: valid/ready handshake, load-use interlock (bubble insertion), flush, illegal-instruction trap state.
// - Supports optional sub-word load/store and AUIPC.
// - Sits between instruction fetch/IF-ID register and execute stage; ex_* outputs feed ALU, branch unit and data memory.
// PARAMETERS
// - SUBWORD_EN     1  1: decode lb/lh/lbu/lhu/sb/sh; 0: these raise ill_instr.
// - AUIPC_EN       1  1: decode auipc (alu_op=ALU_ADD, ex_alu_src_pc=1); 0: illegal.
// - LOAD_USE_BUBBLES 1  Bubbles inserted on load-use hazard; range 1..3.
// PORTS
// - clk              in   1   Clock; all state on rising edge.
// - rst_n            in   1   Asynchronous active-low reset.
// - in_valid         in   1   instruction is valid.
// - in_ready         out  1   Stage accepts instruction this cycle.
// - instruction      in   32  Raw instruction word.
// - flush            in   1   Branch/jump taken in EX; kill held and incoming instruction.
// - ex_ready         in   1   Execute stage accepts bundle.
// - ex_valid         out  1   Bundle valid.
// - ex_rs1, ex_rs2, ex_rd  out 5  Register indices of held instruction.
// - ex_alu_op        out  4   ALU operation code.
// - ex_alu_src       out  1   1: operand B = immediate.
// - ex_alu_src_pc    out  1   1: operand A = pc (auipc).
// - ex_branch_enable out  1   Branch instruction.
// - ex_branch_mode   out  3   Comparison code.
// - ex_jump_enable, ex_jump_reg, ex_pc_to_reg  out 1  Jump controls.
// - ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg  out 1  Writeback/memory controls.
// - ex_mem_size      out  2   00 byte, 01 half, 10 word.
// - ex_mem_unsigned  out  1   Zero-extend load data.
// - trap             out  1   In TRAP state.
// BEHAVIOUR
// - Reset: all ex_* outputs 0, ex_valid=0, trap=0, state RUN, bubble counter 0. in_ready=1 combinationally in RUN.
// - Latency: 1 cycle; instruction accepted (in_valid&&in_ready) at edge N appears on ex_* after edge N.
// - Handshake: ex_* stable while ex_valid&&!ex_ready. in_ready = (state==RUN) && !hazard && (!ex_valid || ex_ready).
// - Hazard: ex_valid && ex_mem_to_reg && ex_rd!=0 && (ex_rd==rs1 || ex_rd==rs2) of incoming instruction.
//   - rs2 compared only for R-type, branch and store formats.
// - Hazard with ex_ready: go to BUBBLE; load counter with LOAD_USE_BUBBLES-1; register ex_valid=1 with all controls 0 (bubble).
// - States:
//   - RUN -> BUBBLE on hazard with ex_ready.
//   - RUN -> TRAP when illegal instruction accepted.
//   - BUBBLE: emit a bubble each cycle ex_ready; decrement counter; at 0 -> RUN.
//   - BUBBLE: accepted instruction is not consumed; it is re-presented by upstream.
//   - TRAP: in_ready=0, ex_valid=0, trap=1; leave to RUN only on flush.
// - Illegal: unmatched opcode/funct3/funct7 or disabled feature.
//   - Bundle loaded with ill_instr semantics: all enables 0, ex_valid=0. trap asserts next cycle.
// - Flush: highest priority; next edge ex_valid=0, controls 0, counter 0, state RUN; same-cycle input dropped.
// - Flush and reset mid-BUBBLE both discard remaining bubbles.
// - x0 destination: ex_reg_write_enable forced 0 when rd==0.
// - Unimplemented (fence, csr, ecall): illegal.
// STRUCTURE
// - control_pkg: opcode group constants, ALU codes, comparison codes, mem_size codes, state enum, ctrl bundle struct.
// - Sub-module control_decoder: purely combinational instruction->ctrl bundle + illegal flag, parameters SUBWORD_EN/AUIPC_EN.
// - Top: hazard compare, FSM, bubble counter, ID/EX register.
// TESTING
// - add x3,x1,x2 (0x002081B3), ex_ready=1 -> next cycle ex_valid=1, alu_op=ALU_ADD, rd=3, reg_write=1.
// - lw x5,0(x1) then add x6,x5,x2, LOAD_USE_BUBBLES=2:
//   - 2 bubbles (ex_valid=1, all enables 0); in_ready=0 for 2 cycles; add issued on 3rd.
// - ex_ready=0 for 3 cycles with sw held -> ex_* unchanged, in_ready=0; released on ex_ready=1.
// - Opcode 0x0F (fence) -> trap=1 next cycle, in_ready=0; flush=1 -> trap=0, in_ready=1.
// - SUBWORD_EN=0: lb (funct3=000, opcode 0x03) -> trap; SUBWORD_EN=1: ex_mem_size=00, mem_unsigned=0.
// - flush coincident with hazard bubble -> next cycle ex_valid=0, state RUN.
// - rst_n low mid-BUBBLE -> asynchronous clear: ex_valid=0, state RUN.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings and the control bundle carried from the ID stage to the execute stage.
package control_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned BR_W    = 3;
    localparam int unsigned MSIZE_W = 2;
    localparam int unsigned CNT_W   = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_W-1:0] ALU_LUI  = 4'd10;

    localparam logic [MSIZE_W-1:0] MEM_BYTE = 2'b00;
    localparam logic [MSIZE_W-1:0] MEM_HALF = 2'b01;
    localparam logic [MSIZE_W-1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {ST_RUN, ST_BUBBLE, ST_TRAP} state_t;

    typedef struct packed {
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic [ALU_W-1:0]   alu_op;
        logic               alu_src;
        logic               alu_src_pc;
        logic               branch_enable;
        logic [BR_W-1:0]    branch_mode;
        logic               jump_enable;
        logic               jump_reg;
        logic               pc_to_reg;
        logic               reg_write_enable;
        logic               mem_write_enable;
        logic               mem_to_reg;
        logic [MSIZE_W-1:0] mem_size;
        logic               mem_unsigned;
    } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32I decoder: raw instruction to control bundle plus illegal flag.
module control_decoder
    import control_pkg::*;
#(
    parameter bit SUBWORD_EN = 1'b1,
    parameter bit AUIPC_EN   = 1'b1
) (
    input  logic [XLEN-1:0] instruction,
    output ctrl_t           ctrl,
    output logic            use_rs2,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      d;
    logic       ill;
    logic       u2;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    always_comb begin
        d   = '0;
        ill = 1'b0;
        u2  = 1'b0;
        unique case (opcode)
            OPC_REG: begin
                d.rs1 = instruction[19:15];
                d.rs2 = instruction[24:20];
                d.rd  = instruction[11:7];
                d.reg_write_enable = 1'b1;
                u2 = 1'b1;
                unique case (funct3)
                    3'b000: d.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: d.alu_op = ALU_SLL;
                    3'b010: d.alu_op = ALU_SLT;
                    3'b011: d.alu_op = ALU_SLTU;
                    3'b100: d.alu_op = ALU_XOR;
                    3'b101: d.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: d.alu_op = ALU_OR;
                    default: d.alu_op = ALU_AND;
                endcase
                // Only sub/sra may carry funct7=0100000.
                if (funct7 == 7'b0100000) ill = !(funct3 == 3'b000 || funct3 == 3'b101);
                else if (funct7 != 7'b0000000) ill = 1'b1;
            end
            OPC_IMM: begin
                d.rs1 = instruction[19:15];
                d.rd  = instruction[11:7];
                d.alu_src = 1'b1;
                d.reg_write_enable = 1'b1;
                unique case (funct3)
                    3'b000: d.alu_op = ALU_ADD;
                    3'b001: d.alu_op = ALU_SLL;
                    3'b010: d.alu_op = ALU_SLT;
                    3'b011: d.alu_op = ALU_SLTU;
                    3'b100: d.alu_op = ALU_XOR;
                    3'b101: d.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: d.alu_op = ALU_OR;
                    default: d.alu_op = ALU_AND;
                endcase
                if (funct3 == 3'b001) ill = (funct7 != 7'b0000000);
                if (funct3 == 3'b101) ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_LOAD: begin
                d.rs1 = instruction[19:15];
                d.rd  = instruction[11:7];
                d.alu_op = ALU_ADD;
                d.alu_src = 1'b1;
                d.mem_to_reg = 1'b1;
                d.reg_write_enable = 1'b1;
                d.mem_size = funct3[1:0];
                d.mem_unsigned = funct3[2];
                unique case (funct3)
                    3'b010:                         ill = 1'b0;
                    3'b000, 3'b001, 3'b100, 3'b101: ill = !SUBWORD_EN;
                    default:                        ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d.rs1 = instruction[19:15];
                d.rs2 = instruction[24:20];
                d.alu_op = ALU_ADD;
                d.alu_src = 1'b1;
                d.mem_write_enable = 1'b1;
                d.mem_size = funct3[1:0];
                u2 = 1'b1;
                unique case (funct3)
                    3'b010:         ill = 1'b0;
                    3'b000, 3'b001: ill = !SUBWORD_EN;
                    default:        ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                d.rs1 = instruction[19:15];
                d.rs2 = instruction[24:20];
                d.alu_op = ALU_SUB;
                d.branch_enable = 1'b1;
                d.branch_mode = funct3;
                u2 = 1'b1;
                ill = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL: begin
                d.rd = instruction[11:7];
                d.jump_enable = 1'b1;
                d.pc_to_reg = 1'b1;
                d.reg_write_enable = 1'b1;
            end
            OPC_JALR: begin
                d.rs1 = instruction[19:15];
                d.rd  = instruction[11:7];
                d.alu_op = ALU_ADD;
                d.alu_src = 1'b1;
                d.jump_enable = 1'b1;
                d.jump_reg = 1'b1;
                d.pc_to_reg = 1'b1;
                d.reg_write_enable = 1'b1;
                ill = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                d.rd = instruction[11:7];
                d.alu_op = ALU_LUI;
                d.alu_src = 1'b1;
                d.reg_write_enable = 1'b1;
            end
            OPC_AUIPC: begin
                d.rd = instruction[11:7];
                d.alu_op = ALU_ADD;
                d.alu_src = 1'b1;
                d.alu_src_pc = 1'b1;
                d.reg_write_enable = 1'b1;
                ill = !AUIPC_EN;
            end
            default: ill = 1'b1;
        endcase
        if (d.rd == '0) d.reg_write_enable = 1'b0;
    end

    assign ctrl    = ill ? '0 : d;
    assign use_rs2 = u2 && !ill;
    assign illegal = ill;

endmodule

// File: rtl/control_decode_stage.sv
// ID stage: decode, load-use interlock, flush and illegal-instruction trap around the ID/EX register.
module control_decode_stage
    import control_pkg::*;
#(
    parameter bit          SUBWORD_EN       = 1'b1,
    parameter bit          AUIPC_EN         = 1'b1,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    instruction,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [REG_W-1:0]   ex_rs1,
    output logic [REG_W-1:0]   ex_rs2,
    output logic [REG_W-1:0]   ex_rd,
    output logic [ALU_W-1:0]   ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_alu_src_pc,
    output logic               ex_branch_enable,
    output logic [BR_W-1:0]    ex_branch_mode,
    output logic               ex_jump_enable,
    output logic               ex_jump_reg,
    output logic               ex_pc_to_reg,
    output logic               ex_reg_write_enable,
    output logic               ex_mem_write_enable,
    output logic               ex_mem_to_reg,
    output logic [MSIZE_W-1:0] ex_mem_size,
    output logic               ex_mem_unsigned,
    output logic               trap
);

    ctrl_t            dec;
    logic             dec_use_rs2;
    logic             dec_illegal;
    ctrl_t            ex;
    logic             ex_valid_q;
    logic             trap_q;
    state_t           state;
    logic [CNT_W-1:0] bubble_cnt;
    logic             hazard;

    control_decoder #(
        .SUBWORD_EN (SUBWORD_EN),
        .AUIPC_EN   (AUIPC_EN)
    ) u_decoder (
        .instruction (instruction),
        .ctrl        (dec),
        .use_rs2     (dec_use_rs2),
        .illegal     (dec_illegal)
    );

    // Unused source fields decode to x0, so they can never match a nonzero load rd.
    assign hazard = in_valid && ex_valid_q && ex.mem_to_reg && (ex.rd != '0) &&
                    ((ex.rd == dec.rs1) || (dec_use_rs2 && (ex.rd == dec.rs2)));

    assign in_ready = (state == ST_RUN) && !hazard && (!ex_valid_q || ex_ready);

    // Flush beats everything; a bubble is a valid bundle with every control cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            bubble_cnt <= '0;
            ex         <= '0;
            ex_valid_q <= 1'b0;
            trap_q     <= 1'b0;
        end else if (flush) begin
            state      <= ST_RUN;
            bubble_cnt <= '0;
            ex         <= '0;
            ex_valid_q <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (hazard && ex_ready) begin
                        ex         <= '0;
                        ex_valid_q <= 1'b1;
                        bubble_cnt <= CNT_W'(LOAD_USE_BUBBLES - 1);
                        state      <= (LOAD_USE_BUBBLES > 1) ? ST_BUBBLE : ST_RUN;
                    end else if (in_valid && in_ready) begin
                        if (dec_illegal) begin
                            ex         <= '0;
                            ex_valid_q <= 1'b0;
                            trap_q     <= 1'b1;
                            state      <= ST_TRAP;
                        end else begin
                            ex         <= dec;
                            ex_valid_q <= 1'b1;
                        end
                    end else if (ex_ready) begin
                        ex_valid_q <= 1'b0;
                    end
                end
                ST_BUBBLE: begin
                    if (ex_ready) begin
                        ex         <= '0;
                        ex_valid_q <= 1'b1;
                        bubble_cnt <= bubble_cnt - CNT_W'(1);
                        if (bubble_cnt <= CNT_W'(1)) state <= ST_RUN;
                    end
                end
                ST_TRAP: begin
                    ex_valid_q <= 1'b0;
                    trap_q     <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign ex_valid            = ex_valid_q;
    assign ex_rs1              = ex.rs1;
    assign ex_rs2              = ex.rs2;
    assign ex_rd               = ex.rd;
    assign ex_alu_op           = ex.alu_op;
    assign ex_alu_src          = ex.alu_src;
    assign ex_alu_src_pc       = ex.alu_src_pc;
    assign ex_branch_enable    = ex.branch_enable;
    assign ex_branch_mode      = ex.branch_mode;
    assign ex_jump_enable      = ex.jump_enable;
    assign ex_jump_reg         = ex.jump_reg;
    assign ex_pc_to_reg        = ex.pc_to_reg;
    assign ex_reg_write_enable = ex.reg_write_enable;
    assign ex_mem_write_enable = ex.mem_write_enable;
    assign ex_mem_to_reg       = ex.mem_to_reg;
    assign ex_mem_size         = ex.mem_size;
    assign ex_mem_unsigned     = ex.mem_unsigned;
    assign trap                = trap_q;

endmodule

// File: tb/tb_control_decode_stage.sv
// Directed bench for the ID stage: decode, interlock, stall, trap, flush and reset.
module tb_control_decode_stage;

    localparam logic [31:0] ADD_X3  = 32'h002081B3;
    localparam logic [31:0] ADD_X6  = 32'h00228333;
    localparam logic [31:0] ADD_X0  = 32'h00208033;
    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] SW_X2   = 32'h0020A423;
    localparam logic [31:0] FENCE   = 32'h0000000F;
    localparam logic [31:0] LB_X7   = 32'h00008383;
    localparam logic [31:0] LHU_X8  = 32'h0000D403;
    localparam logic [31:0] AUIPC_9 = 32'h00001497;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, flush, ex_ready;
    logic [31:0] instruction;

    logic in_ready, ex_valid, ex_alu_src, ex_alu_src_pc, ex_branch_enable;
    logic ex_jump_enable, ex_jump_reg, ex_pc_to_reg, ex_reg_write_enable;
    logic ex_mem_write_enable, ex_mem_to_reg, ex_mem_unsigned, trap;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_alu_op;
    logic [2:0] ex_branch_mode;
    logic [1:0] ex_mem_size;

    logic ns_in_ready, ns_ex_valid, ns_alu_src, ns_alu_src_pc, ns_branch_enable;
    logic ns_jump_enable, ns_jump_reg, ns_pc_to_reg, ns_reg_write_enable;
    logic ns_mem_write_enable, ns_mem_to_reg, ns_mem_unsigned, ns_trap;
    logic [4:0] ns_rs1, ns_rs2, ns_rd;
    logic [3:0] ns_alu_op;
    logic [2:0] ns_branch_mode;
    logic [1:0] ns_mem_size;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_decode_stage #(.SUBWORD_EN(1'b1), .AUIPC_EN(1'b1), .LOAD_USE_BUBBLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_alu_src_pc(ex_alu_src_pc),
        .ex_branch_enable(ex_branch_enable), .ex_branch_mode(ex_branch_mode),
        .ex_jump_enable(ex_jump_enable), .ex_jump_reg(ex_jump_reg), .ex_pc_to_reg(ex_pc_to_reg),
        .ex_reg_write_enable(ex_reg_write_enable), .ex_mem_write_enable(ex_mem_write_enable),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_size(ex_mem_size),
        .ex_mem_unsigned(ex_mem_unsigned), .trap(trap)
    );

    control_decode_stage #(.SUBWORD_EN(1'b0), .AUIPC_EN(1'b1), .LOAD_USE_BUBBLES(2)) u_nosub (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ns_in_ready),
        .instruction(instruction), .flush(flush), .ex_ready(ex_ready), .ex_valid(ns_ex_valid),
        .ex_rs1(ns_rs1), .ex_rs2(ns_rs2), .ex_rd(ns_rd), .ex_alu_op(ns_alu_op),
        .ex_alu_src(ns_alu_src), .ex_alu_src_pc(ns_alu_src_pc),
        .ex_branch_enable(ns_branch_enable), .ex_branch_mode(ns_branch_mode),
        .ex_jump_enable(ns_jump_enable), .ex_jump_reg(ns_jump_reg), .ex_pc_to_reg(ns_pc_to_reg),
        .ex_reg_write_enable(ns_reg_write_enable), .ex_mem_write_enable(ns_mem_write_enable),
        .ex_mem_to_reg(ns_mem_to_reg), .ex_mem_size(ns_mem_size),
        .ex_mem_unsigned(ns_mem_unsigned), .trap(ns_trap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; combinational in_ready is sampled 1 ns later.
    task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic er);
        @(negedge clk);
        in_valid = v; instruction = ins; flush = fl; ex_ready = er;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instruction = '0; flush = 1'b0; ex_ready = 1'b1;
        #12;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_alu_op", 32'(ex_alu_op), 0);
        @(negedge clk) rst_n = 1'b1;

        drive(1'b1, ADD_X3, 1'b0, 1'b1);
        chk("add_in_ready", 32'(in_ready), 1);
        tick();
        chk("add_valid", 32'(ex_valid), 1);
        chk("add_alu_op", 32'(ex_alu_op), 0);
        chk("add_rd", 32'(ex_rd), 3);
        chk("add_rs1", 32'(ex_rs1), 1);
        chk("add_rs2", 32'(ex_rs2), 2);
        chk("add_we", 32'(ex_reg_write_enable), 1);
        chk("add_alu_src", 32'(ex_alu_src), 0);

        drive(1'b1, LW_X5, 1'b0, 1'b1);
        tick();
        chk("lw_m2r", 32'(ex_mem_to_reg), 1);
        chk("lw_rd", 32'(ex_rd), 5);
        chk("lw_size", 32'(ex_mem_size), 2);
        chk("lw_alu_src", 32'(ex_alu_src), 1);

        // Dependent add: two bubbles, then issue.
        drive(1'b1, ADD_X6, 1'b0, 1'b1);
        chk("hz_in_ready0", 32'(in_ready), 0);
        tick();
        chk("bub1_valid", 32'(ex_valid), 1);
        chk("bub1_we", 32'(ex_reg_write_enable), 0);
        chk("bub1_m2r", 32'(ex_mem_to_reg), 0);
        chk("bub1_rd", 32'(ex_rd), 0);
        drive(1'b1, ADD_X6, 1'b0, 1'b1);
        chk("hz_in_ready1", 32'(in_ready), 0);
        tick();
        chk("bub2_valid", 32'(ex_valid), 1);
        chk("bub2_we", 32'(ex_reg_write_enable), 0);
        drive(1'b1, ADD_X6, 1'b0, 1'b1);
        chk("hz_in_ready2", 32'(in_ready), 1);
        tick();
        chk("add6_rd", 32'(ex_rd), 6);
        chk("add6_rs1", 32'(ex_rs1), 5);
        chk("add6_we", 32'(ex_reg_write_enable), 1);

        // Store held under back-pressure.
        drive(1'b1, SW_X2, 1'b0, 1'b1);
        tick();
        chk("sw_mem_we", 32'(ex_mem_write_enable), 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADD_X3, 1'b0, 1'b0);
            chk("stall_in_ready", 32'(in_ready), 0);
            tick();
            chk("stall_valid", 32'(ex_valid), 1);
            chk("stall_mem_we", 32'(ex_mem_write_enable), 1);
            chk("stall_rs2", 32'(ex_rs2), 2);
            chk("stall_size", 32'(ex_mem_size), 2);
        end
        drive(1'b1, ADD_X3, 1'b0, 1'b1);
        chk("release_in_ready", 32'(in_ready), 1);
        tick();
        chk("release_rd", 32'(ex_rd), 3);
        chk("release_mem_we", 32'(ex_mem_write_enable), 0);

        // Fence traps until flush.
        drive(1'b1, FENCE, 1'b0, 1'b1);
        tick();
        chk("fence_trap", 32'(trap), 1);
        chk("fence_valid", 32'(ex_valid), 0);
        chk("fence_in_ready", 32'(in_ready), 0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("flush_trap", 32'(trap), 0);
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);

        // Sub-word loads: decoded by one instance, illegal in the other.
        drive(1'b1, LB_X7, 1'b0, 1'b1);
        tick();
        chk("lb_valid", 32'(ex_valid), 1);
        chk("lb_size", 32'(ex_mem_size), 0);
        chk("lb_unsigned", 32'(ex_mem_unsigned), 0);
        chk("lb_m2r", 32'(ex_mem_to_reg), 1);
        chk("lb_ns_trap", 32'(ns_trap), 1);
        chk("lb_ns_valid", 32'(ns_ex_valid), 0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("ns_flush_trap", 32'(ns_trap), 0);
        drive(1'b1, LHU_X8, 1'b0, 1'b1);
        tick();
        chk("lhu_size", 32'(ex_mem_size), 1);
        chk("lhu_unsigned", 32'(ex_mem_unsigned), 1);
        chk("lhu_rd", 32'(ex_rd), 8);
        chk("lhu_ns_trap", 32'(ns_trap), 1);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();

        drive(1'b1, AUIPC_9, 1'b0, 1'b1);
        tick();
        chk("auipc_src_pc", 32'(ex_alu_src_pc), 1);
        chk("auipc_src", 32'(ex_alu_src), 1);
        chk("auipc_rd", 32'(ex_rd), 9);
        chk("auipc_we", 32'(ex_reg_write_enable), 1);
        drive(1'b1, ADD_X0, 1'b0, 1'b1);
        tick();
        chk("x0_valid", 32'(ex_valid), 1);
        chk("x0_we", 32'(ex_reg_write_enable), 0);

        // Flush coincident with a load-use hazard.
        drive(1'b1, LW_X5, 1'b0, 1'b1);
        tick();
        drive(1'b1, ADD_X6, 1'b1, 1'b1);
        chk("fh_in_ready", 32'(in_ready), 0);
        tick();
        chk("fh_valid", 32'(ex_valid), 0);
        chk("fh_trap", 32'(trap), 0);
        chk("fh_in_ready_after", 32'(in_ready), 1);
        drive(1'b1, ADD_X6, 1'b0, 1'b1);
        tick();
        chk("fh_issue_rd", 32'(ex_rd), 6);

        // Asynchronous reset in the middle of a bubble run.
        drive(1'b1, LW_X5, 1'b0, 1'b1);
        tick();
        drive(1'b1, ADD_X6, 1'b0, 1'b1);
        tick();
        chk("rb_bubble_valid", 32'(ex_valid), 1);
        chk("rb_bubble_in_ready", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_valid", 32'(ex_valid), 0);
        chk("rb_in_ready", 32'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        drive(1'b1, ADD_X6, 1'b0, 1'b1);
        chk("rb_run_in_ready", 32'(in_ready), 1);
        tick();
        chk("rb_issue_rd", 32'(ex_rd), 6);
        chk("rb_issue_we", 32'(ex_reg_write_enable), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
